rst_sequencer: RTL and testbench

RST_SEQUENCER -- requirements
Module: rst_sequencer

---
 rtl/rst_sequencer.sv | 173 +++++++++++++++++
 tb/tb_rst_sequencer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rst_sequencer.sv
// rst_sequencer: power-on / DCM reset sequencer.
// Pulses the DCM reset and waits for lock, retrying a limited number of
// times. Once lock is seen, it releases three active-low reset stages in
// order: memory, then peripherals, then CPU. A lock loss or a software
// reset request aborts the sequence.
// Ports:
//   CLK      free-running board clock (taken before the DCM)
//   RST_X    asynchronous active-low reset
//   LOCKED   DCM lock, asynchronous to CLK
//   SW_RST   active-high software/button reset request, synchronous to CLK
//   DCM_RST  active-high reset driven to the DCM
//   RST_X_O  active-low staged resets [0] memory, [1] peripherals, [2] CPU
//   READY    high once all stages are released
//   FAIL     high once lock retries are exhausted
module rst_sequencer #(
    parameter int unsigned DCM_RST_CYCLES = 4,
    parameter int unsigned LOCK_TIMEOUT   = 1023,
    parameter int unsigned STAGE_DELAY    = 16,
    parameter int unsigned MAX_RETRY      = 3
) (
    input  logic       CLK,
    input  logic       RST_X,
    input  logic       LOCKED,
    input  logic       SW_RST,
    output logic       DCM_RST,
    output logic [2:0] RST_X_O,
    output logic       READY,
    output logic       FAIL
);

    localparam int unsigned CNT_W   = 16;
    localparam int unsigned RETRY_W = 2;

    localparam logic [CNT_W-1:0]   DCM_LAST   = CNT_W'(DCM_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   LOCK_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STAGE_LAST = CNT_W'(STAGE_DELAY - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_DCMRST   = 3'd0,
        S_WAITLOCK = 3'd1,
        S_STAGE0   = 3'd2,
        S_STAGE1   = 3'd3,
        S_STAGE2   = 3'd4,
        S_RUN      = 3'd5,
        S_ERROR    = 3'd6
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [RETRY_W-1:0] retry_inc;
    logic               cnt_clr;
    logic               lock_meta_q, lock_s_q;
    logic               lock_s;
    logic               dcm_rst_q, dcm_rst_d;
    logic [2:0]         rst_x_o_q, rst_x_o_d;
    logic               ready_q, ready_d;
    logic               fail_q, fail_d;

    // Two-flop synchroniser; LOCKED is only ever consumed through lock_s.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= LOCKED;
            lock_s_q    <= lock_meta_q;
        end
    end

    assign lock_s = lock_s_q;

    // State, counters and registered outputs.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state_q   <= S_DCMRST;
            cnt_q     <= '0;
            retry_q   <= '0;
            dcm_rst_q <= 1'b1;
            rst_x_o_q <= 3'b000;
            ready_q   <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            dcm_rst_q <= dcm_rst_d;
            rst_x_o_q <= rst_x_o_d;
            ready_q   <= ready_d;
            fail_q    <= fail_d;
        end
    end

    // Next state, cycle counter and retry counter.
    always_comb begin
        state_d   = state_q;
        retry_d   = retry_q;
        cnt_d     = cnt_q + CNT_W'(1);
        cnt_clr   = 1'b0;
        retry_inc = retry_q + RETRY_W'(1);
        case (state_q)
            S_DCMRST: begin
                if (cnt_q == DCM_LAST) state_d = S_WAITLOCK;
            end
            S_WAITLOCK: begin
                if (lock_s) begin
                    state_d = S_STAGE0;
                end else if (cnt_q == LOCK_LAST) begin
                    retry_d = retry_inc;
                    state_d = (retry_inc == RETRY_MAX) ? S_ERROR : S_DCMRST;
                end
            end
            S_STAGE0, S_STAGE1, S_STAGE2, S_RUN: begin
                // Lock loss outranks a software request.
                if (!lock_s) begin
                    state_d = S_DCMRST;
                end else if (SW_RST) begin
                    // Restart staging; counter pinned at 0 while the request is held.
                    state_d = S_STAGE0;
                    cnt_clr = 1'b1;
                end else if (state_q == S_RUN) begin
                    cnt_clr = 1'b1;
                end else if (cnt_q == STAGE_LAST) begin
                    if (state_q == S_STAGE0) begin
                        state_d = S_STAGE1;
                    end else if (state_q == S_STAGE1) begin
                        state_d = S_STAGE2;
                    end else begin
                        state_d = S_RUN;
                        retry_d = '0;
                    end
                end
            end
            S_ERROR: begin
                cnt_clr = 1'b1;
                if (SW_RST) begin
                    state_d = S_DCMRST;
                    retry_d = '0;
                end
            end
            default: begin
                state_d = S_DCMRST;
            end
        endcase
        if (cnt_clr || (state_d != state_q)) cnt_d = '0;
    end

    // Output values follow the state being entered, so each is a flop.
    always_comb begin
        dcm_rst_d = 1'b0;
        rst_x_o_d = 3'b000;
        ready_d   = 1'b0;
        fail_d    = 1'b0;
        case (state_d)
            S_DCMRST: dcm_rst_d = 1'b1;
            S_STAGE1: rst_x_o_d = 3'b001;
            S_STAGE2: rst_x_o_d = 3'b011;
            S_RUN: begin
                rst_x_o_d = 3'b111;
                ready_d   = 1'b1;
            end
            S_ERROR:  fail_d = 1'b1;
            default:  ;
        endcase
    end

    assign DCM_RST = dcm_rst_q;
    assign RST_X_O = rst_x_o_q;
    assign READY   = ready_q;
    assign FAIL    = fail_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// tb_rst_sequencer: directed bench for rst_sequencer with a per-cycle
// behavioural model (mode + entry time, outputs derived from elapsed cycles)
// and literal event-time checks.
module tb_rst_sequencer;

    localparam int DCM_CYC = 4;
    localparam int LOCK_TO = 20;
    localparam int STG     = 8;
    localparam int MAXR    = 3;

    localparam int M_PULSE = 0;
    localparam int M_WAIT  = 1;
    localparam int M_STAGE = 2;
    localparam int M_ERR   = 3;

    logic       CLK = 1'b0;
    logic       RST_X;
    logic       LOCKED;
    logic       SW_RST;
    logic       DCM_RST;
    logic [2:0] RST_X_O;
    logic       READY;
    logic       FAIL;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    rst_sequencer #(
        .DCM_RST_CYCLES(DCM_CYC),
        .LOCK_TIMEOUT  (LOCK_TO),
        .STAGE_DELAY   (STG),
        .MAX_RETRY     (MAXR)
    ) dut (
        .CLK    (CLK),
        .RST_X  (RST_X),
        .LOCKED (LOCKED),
        .SW_RST (SW_RST),
        .DCM_RST(DCM_RST),
        .RST_X_O(RST_X_O),
        .READY  (READY),
        .FAIL   (FAIL)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, got, want);
        end
    endtask

    // Model: current mode, edge index of entry into that mode, retries used.
    int   m_mode   = M_PULSE;
    int   m_anchor = 0;
    int   m_n      = 0;
    int   m_retry  = 0;
    logic m_l1     = 1'b0;
    logic m_l2     = 1'b0;
    int   mn_mode, mn_anchor, mn_retry, m_nn, m_el;

    always_comb begin
        m_nn      = m_n + 1;
        m_el      = m_nn - m_anchor;
        mn_mode   = m_mode;
        mn_anchor = m_anchor;
        mn_retry  = m_retry;
        case (m_mode)
            M_PULSE: begin
                if (m_el == DCM_CYC) begin
                    mn_mode   = M_WAIT;
                    mn_anchor = m_nn;
                end
            end
            M_WAIT: begin
                if (m_l2) begin
                    mn_mode   = M_STAGE;
                    mn_anchor = m_nn;
                end else if (m_el == LOCK_TO) begin
                    mn_retry  = m_retry + 1;
                    mn_mode   = (mn_retry == MAXR) ? M_ERR : M_PULSE;
                    mn_anchor = m_nn;
                end
            end
            M_STAGE: begin
                if (!m_l2) begin
                    mn_mode   = M_PULSE;
                    mn_anchor = m_nn;
                end else if (SW_RST) begin
                    mn_anchor = m_nn;
                end else if (m_el == 3 * STG) begin
                    mn_retry = 0;
                end
            end
            default: begin
                if (SW_RST) begin
                    mn_mode   = M_PULSE;
                    mn_anchor = m_nn;
                    mn_retry  = 0;
                end
            end
        endcase
    end

    always @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            m_mode   <= M_PULSE;
            m_anchor <= 0;
            m_n      <= 0;
            m_retry  <= 0;
            m_l1     <= 1'b0;
            m_l2     <= 1'b0;
        end else begin
            m_mode   <= mn_mode;
            m_anchor <= mn_anchor;
            m_retry  <= mn_retry;
            m_n      <= m_nn;
            m_l1     <= LOCKED;
            m_l2     <= m_l1;
        end
    end

    // {DCM_RST, RST_X_O[2:0], READY, FAIL} expected for a mode and elapsed time.
    function automatic logic [5:0] exp_out(input int mode, input int el);
        int         k;
        logic [2:0] r;
        k = el / STG;
        if (k > 3) k = 3;
        r = 3'b000;
        if (mode == M_STAGE) begin
            for (int i = 0; i < 3; i++) if (i < k) r[i] = 1'b1;
        end
        return {mode == M_PULSE, r, (mode == M_STAGE) && (k == 3), mode == M_ERR};
    endfunction

    logic [5:0] ex;
    assign ex = exp_out(m_mode, m_n - m_anchor);

    always @(negedge CLK) begin
        check("cyc_dcm_rst", int'(DCM_RST), int'(ex[5]));
        check("cyc_rst_x_o", int'(RST_X_O), int'(ex[4:2]));
        check("cyc_ready",   int'(READY),   int'(ex[1]));
        check("cyc_fail",    int'(FAIL),    int'(ex[0]));
    end

    // Event recorder over a bounded window of cycles.
    int w_d_rise, w_d_fall, w_rises, w_high, w_r0, w_r1, w_r2, w_rdy, w_zero, w_fail;

    task automatic watch(input int n);
        logic pd;
        pd = DCM_RST;
        w_d_rise = -1; w_d_fall = -1; w_rises = 0; w_high = 0;
        w_r0 = -1; w_r1 = -1; w_r2 = -1; w_rdy = -1; w_zero = -1; w_fail = -1;
        repeat (n) begin
            @(negedge CLK);
            if (DCM_RST && !pd) begin
                w_rises++;
                if (w_d_rise < 0) w_d_rise = cyc;
            end
            if (!DCM_RST && pd && w_d_fall < 0) w_d_fall = cyc;
            if (DCM_RST) w_high++;
            pd = DCM_RST;
            if (RST_X_O[0] && w_r0 < 0) w_r0 = cyc;
            if (RST_X_O[1] && w_r1 < 0) w_r1 = cyc;
            if (RST_X_O[2] && w_r2 < 0) w_r2 = cyc;
            if (READY && w_rdy < 0) w_rdy = cyc;
            if (RST_X_O == 3'b000 && w_zero < 0) w_zero = cyc;
            if (FAIL && w_fail < 0) w_fail = cyc;
        end
    endtask

    initial begin
        int c0, e, a;
        RST_X  = 1'b0;
        LOCKED = 1'b0;
        SW_RST = 1'b0;
        repeat (2) @(negedge CLK);
        check("rst_dcm",   int'(DCM_RST), 1);
        check("rst_out",   int'(RST_X_O), 0);
        check("rst_ready", int'(READY),   0);
        check("rst_fail",  int'(FAIL),    0);

        // Normal bring-up, LOCKED raised at cycle 10 after release.
        RST_X = 1'b1;
        c0 = cyc;
        watch(9);
        check("up_dcm_fall", w_d_fall, c0 + 4);
        LOCKED = 1'b1;
        e = cyc + 1;
        watch(40);
        check("up_r0",    w_r0,    e + 10);
        check("up_r1",    w_r1,    e + 18);
        check("up_r2",    w_r2,    e + 26);
        check("up_ready", w_rdy,   e + 26);
        check("up_nodcm", w_rises, 0);

        // Lock loss in RUN, then relock.
        LOCKED = 1'b0;
        e = cyc + 1;
        watch(12);
        check("ll_zero",     w_zero,   e + 2);
        check("ll_dcm_rise", w_d_rise, e + 2);
        check("ll_dcm_fall", w_d_fall, e + 6);
        LOCKED = 1'b1;
        e = cyc + 1;
        watch(35);
        check("ll_relock_ready", w_rdy, e + 26);

        // One-cycle software reset in RUN.
        SW_RST = 1'b1;
        a = cyc + 1;
        @(negedge CLK);
        SW_RST = 1'b0;
        check("sw_out",   int'(RST_X_O), 0);
        check("sw_ready", int'(READY),   0);
        check("sw_dcm",   int'(DCM_RST), 0);
        watch(30);
        check("sw_r0",     w_r0,    a + 8);
        check("sw_ready2", w_rdy,   a + 24);
        check("sw_nodcm",  w_rises, 0);

        // Software reset coinciding with lock loss, then retries to ERROR.
        LOCKED = 1'b0;
        e = cyc + 1;
        @(negedge CLK);
        @(negedge CLK);
        SW_RST = 1'b1;
        @(negedge CLK);
        SW_RST = 1'b0;
        check("prio_dcm", int'(DCM_RST), 1);
        check("prio_out", int'(RST_X_O), 0);
        watch(80);
        check("err_rises", w_rises, 2);
        check("err_high",  w_high,  11);
        check("err_fail",  w_fail,  e + 74);
        watch(20);
        check("err_hold_fail", int'(FAIL),    1);
        check("err_hold_out",  int'(RST_X_O), 0);
        check("err_hold_dcm",  w_rises,       0);

        // Software reset leaves ERROR.
        SW_RST = 1'b1;
        @(negedge CLK);
        SW_RST = 1'b0;
        check("clr_fail", int'(FAIL),    0);
        check("clr_dcm",  int'(DCM_RST), 1);

        // Async reset mid-STAGE1.
        repeat (6) @(negedge CLK);
        LOCKED = 1'b1;
        e = cyc + 1;
        repeat (14) @(negedge CLK);
        check("mid_stage1", int'(RST_X_O), 1);
        #3;
        RST_X = 1'b0;
        #1;
        check("async_dcm",   int'(DCM_RST), 1);
        check("async_out",   int'(RST_X_O), 0);
        check("async_ready", int'(READY),   0);
        check("async_fail",  int'(FAIL),    0);
        @(negedge CLK);
        RST_X = 1'b1;
        c0 = cyc;
        watch(9);
        check("rel_dcm_fall", w_d_fall, c0 + 4);
        check("rel_no_r0",    w_r0,     -1);
        watch(25);
        check("rel_ready", w_rdy, c0 + 29);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
